// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_bank
// Description : Bank of independent programmable clock dividers with glitch-
//               free divisor updates, a lock indicator and a downstream reset.
//               Each channel produces a registered square wave (clk_out) and
//               a one-cycle pulse on every clk_out rising edge (tick).
//               A new divisor is staged as "pending" and only becomes active
//               at a period boundary. No period is ever cut short.
// Ports       : clk        - single clock, rising edge
//               rst_n      - asynchronous active-low reset
//               div_wr     - divisor write strobe
//               div_ch     - channel index for div_wr (>= NUM_CH ignored)
//               div_val    - new divisor (0 and 1 behave as 2)
//               en         - per-channel run enable
//               clk_out    - per-channel divided clock (registered)
//               tick       - per-channel pulse on clk_out rising edge
//               locked     - all divisors settled
//               rst_out_n  - downstream reset, async assert / sync release
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_bank #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              div_wr,
  input  logic [2:0]        div_ch,
  input  logic [CNT_W-1:0]  div_val,
  input  logic [NUM_CH-1:0] en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              locked,
  output logic              rst_out_n
);

  localparam int              LCW       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCW-1:0]  LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);

  // Divisors below 2 cannot form a square wave; they run as 2.
  function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  // ceil(d/2), one bit wider so the largest divisor cannot overflow.
  function automatic logic [CNT_W:0] half_up(input logic [CNT_W-1:0] d);
    return ({1'b0, d} + (CNT_W+1)'(1)) >> 1;
  endfunction

  // A write is accepted only when it targets an existing channel.
  logic wr_ok;
  assign wr_ok = div_wr && ({29'd0, div_ch} < NUM_CH);

  // A channel is settled when nothing is staged or it is not running.
  logic [NUM_CH-1:0] settled;

  // --------------------------------------------------------------------------
  // Divider channels
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [CNT_W-1:0] act_q,  act_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             run_q,  run_d;
    logic             clk_q,  clk_d;
    logic             tick_q, tick_d;
    logic             wr_hit;
    logic             wrap;
    logic [CNT_W-1:0] act_eff;
    logic [CNT_W:0]   act_half;

    assign wr_hit   = wr_ok && (div_ch == 3'(i));
    assign act_eff  = eff_div(act_q);
    assign act_half = half_up(act_eff);
    assign wrap     = (cnt_q == act_eff - CNT_W'(1));

    always_comb begin
      pend_d = wr_hit ? div_val : pend_q;
      cnt_d  = cnt_q;
      act_d  = act_q;
      run_d  = en[i];
      clk_d  = 1'b0;
      if (!en[i]) begin
        cnt_d = '0;
      end else if (!run_q || wrap) begin
        // Period boundary (wrap or restart): the staged divisor takes over.
        // A write landing this same cycle is still only in pend_d, so it
        // waits for the next boundary. Count 0 is always in the high phase.
        cnt_d = '0;
        act_d = pend_q;
        clk_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        clk_d = ({1'b0, cnt_d} < act_half);
      end
      tick_d = clk_d & ~clk_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        act_q  <= DEF_DIV;
        pend_q <= DEF_DIV;
        run_q  <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        pend_q <= pend_d;
        run_q  <= run_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign settled[i] = (pend_q == act_q) || !en[i];
    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

  // --------------------------------------------------------------------------
  // Lock state machine and downstream reset
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    LOCKED     = 2'd1,
    RELOCK     = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           locked_q, locked_d;
  logic [1:0]     rst_sync_q, rst_sync_d;
  logic           all_settled;

  assign all_settled = &settled;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      RESET_WAIT: begin
        if (lock_cnt_q == LOCK_LAST) begin
          state_d    = LOCKED;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end
      LOCKED: begin
        if (wr_ok) begin
          state_d    = RELOCK;
          lock_cnt_d = '0;
        end
      end
      RELOCK: begin
        // The settle count only runs once every staged divisor is live;
        // any new accepted write starts the wait over.
        if (wr_ok || !all_settled) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_d    = LOCKED;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end
      default: begin
        state_d    = RESET_WAIT;
        lock_cnt_d = '0;
      end
    endcase
    locked_d   = (state_d == LOCKED);
    // Once the initial wait has ended the chain input stays high; only
    // rst_n can pull it (and the state) back.
    rst_sync_d = {rst_sync_q[0], (state_q != RESET_WAIT)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_WAIT;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      rst_sync_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  assign locked    = locked_q;
  assign rst_out_n = rst_sync_q[1];

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_bank
// Description : Directed self-checking bench for clk_div_bank (default
//               parameters). Edge numbers count rising clk edges since the
//               most recent reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              div_wr;
  logic [2:0]        div_ch;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic              locked;
  logic              rst_out_n;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  always #5 clk = ~clk;

  clk_div_bank #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (2),
    .LOCK_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_wr    (div_wr),
    .div_ch    (div_ch),
    .div_val   (div_val),
    .en        (en),
    .clk_out   (clk_out),
    .tick      (tick),
    .locked    (locked),
    .rst_out_n (rst_out_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  // Expected phase of a channel with divisor d whose period started at edge s.
  function automatic logic ph_hi(input int e, input int s, input int d);
    return ((e - s) % d) < ((d + 1) / 2);
  endfunction
  function automatic logic ph_tk(input int e, input int s, input int d);
    return ((e - s) % d) == 0;
  endfunction

  task automatic check_ch(input logic hi0, input logic tk0, input logic hi1,
                          input logic tk1, input logic exp_locked);
    chk("clk_out", {30'd0, clk_out}, {30'd0, hi1, hi0});
    chk("tick",    {30'd0, tick},    {30'd0, tk1, tk0});
    chk("locked",  {31'd0, locked},  {31'd0, exp_locked});
  endtask

  // Both channels at divisor 2 from reset release: high/tick on odd edges,
  // locked from edge 16, rst_out_n from edge 18.
  task automatic lock_seq();
    for (int k = 1; k <= 18; k++) begin
      cyc();
      chk("seq_clk_out",   {30'd0, clk_out},   (k % 2 == 1) ? 32'd3 : 32'd0);
      chk("seq_tick",      {30'd0, tick},      (k % 2 == 1) ? 32'd3 : 32'd0);
      chk("seq_locked",    {31'd0, locked},    (k >= 16) ? 32'd1 : 32'd0);
      chk("seq_rst_out_n", {31'd0, rst_out_n}, (k >= 18) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    // ---- reset state
    rst_n   = 1'b0;
    en      = 2'b11;
    div_wr  = 1'b0;
    div_ch  = 3'd0;
    div_val = '0;
    cyc();
    cyc();
    chk("rst_clk_out",   {30'd0, clk_out},   32'd0);
    chk("rst_tick",      {30'd0, tick},      32'd0);
    chk("rst_locked",    {31'd0, locked},    32'd0);
    chk("rst_rst_out_n", {31'd0, rst_out_n}, 32'd0);

    // ---- release and initial lock sequence
    rst_n = 1'b1;
    cyc_n = 0;
    lock_seq();
    cyc();                                   // edge 19
    check_ch(1, 1, 1, 1, 1);

    // ---- ch0 D=5 mid-period: current D=2 period ends at edge 21
    div_wr = 1'b1; div_ch = 3'd0; div_val = 8'd5;
    cyc();                                   // edge 20
    div_wr = 1'b0;
    check_ch(0, 0, 0, 0, 0);
    while (cyc_n < 41) begin
      cyc();
      check_ch(ph_hi(cyc_n, 21, 5), ph_tk(cyc_n, 21, 5),
               ph_hi(cyc_n, 1, 2),  ph_tk(cyc_n, 1, 2), cyc_n >= 37);
    end

    // ---- ch1 D=0 (edge 42) then D=1 (edge 44): still period 2
    div_ch = 3'd1;
    while (cyc_n < 62) begin
      div_wr  = (cyc_n + 1 == 42) || (cyc_n + 1 == 44);
      div_val = (cyc_n + 1 == 42) ? 8'd0 : 8'd1;
      cyc();
      div_wr = 1'b0;
      check_ch(ph_hi(cyc_n, 21, 5), ph_tk(cyc_n, 21, 5),
               ph_hi(cyc_n, 1, 2),  ph_tk(cyc_n, 1, 2), cyc_n >= 61);
    end

    // ---- write to channel 5 (nonexistent): no effect, lock holds
    div_ch  = 3'd5;
    div_val = 8'd7;
    while (cyc_n < 72) begin
      div_wr = (cyc_n + 1 <= 64);
      cyc();
      div_wr = 1'b0;
      check_ch(ph_hi(cyc_n, 21, 5), ph_tk(cyc_n, 21, 5),
               ph_hi(cyc_n, 1, 2),  ph_tk(cyc_n, 1, 2), 1'b1);
    end

    // ---- en[0] low for edges 73..79, restart sampled at edge 80
    en = 2'b10;
    while (cyc_n < 79) begin
      cyc();
      check_ch(0, 0, ph_hi(cyc_n, 1, 2), ph_tk(cyc_n, 1, 2), 1'b1);
    end
    en = 2'b11;
    while (cyc_n < 90) begin
      cyc();
      check_ch(ph_hi(cyc_n, 80, 5), ph_tk(cyc_n, 80, 5),
               ph_hi(cyc_n, 1, 2),  ph_tk(cyc_n, 1, 2), 1'b1);
    end

    // ---- D=4 on the wrap at edge 95, D=6 at edge 96: 6 applies at edge 100
    div_ch = 3'd0;
    while (cyc_n < 120) begin
      div_wr  = (cyc_n + 1 == 95) || (cyc_n + 1 == 96);
      div_val = (cyc_n + 1 == 95) ? 8'd4 : 8'd6;
      cyc();
      div_wr = 1'b0;
      if (cyc_n < 100)
        check_ch(ph_hi(cyc_n, 80, 5), ph_tk(cyc_n, 80, 5),
                 ph_hi(cyc_n, 1, 2),  ph_tk(cyc_n, 1, 2), !(cyc_n >= 95));
      else
        check_ch(ph_hi(cyc_n, 100, 6), ph_tk(cyc_n, 100, 6),
                 ph_hi(cyc_n, 1, 2),   ph_tk(cyc_n, 1, 2), cyc_n >= 116);
    end

    // ---- asynchronous reset pulse mid-period (ch0 high at edge 120)
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_clk_out",   {30'd0, clk_out},   32'd0);
    chk("arst_tick",      {30'd0, tick},      32'd0);
    chk("arst_locked",    {31'd0, locked},    32'd0);
    chk("arst_rst_out_n", {31'd0, rst_out_n}, 32'd0);
    cyc();
    chk("arst_hold_tick",    {30'd0, tick},    32'd0);
    chk("arst_hold_clk_out", {30'd0, clk_out}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc_n = 0;
    lock_seq();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of independent divider channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 8, meaning divisor and counter width in bits.
REQ-003 SHALL have parameter DEFAULT_DIV, default 2, meaning divisor loaded into every channel at reset.
REQ-004 SHALL have parameter LOCK_CYCLES, default 16, meaning settle cycles before locked asserts.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic SHALL be rising-edge clk.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port div_wr, input, 1, divisor write strobe, sampled each cycle.
REQ-008 SHALL have port div_ch, input, 3, target channel index for div_wr.
REQ-009 SHALL have port div_val, input, CNT_W, new divisor D.
REQ-010 SHALL have port en, input, NUM_CH, per-channel run enable.
REQ-011 SHALL have port clk_out, output, NUM_CH, registered divided square wave per channel.
REQ-012 SHALL have port tick, output, NUM_CH, one-cycle pulse coincident with each clk_out rising edge.
REQ-013 SHALL have port locked, output, 1, high when all divisors are settled.
REQ-014 SHALL have port rst_out_n, output, 1, downstream reset, async assert, sync release.

Function
REQ-015 Each channel SHALL hold an active divisor, a pending divisor, and a counter cnt of CNT_W bits.
REQ-016 Effective divisor SHALL be max(D, 2); D of 0 or 1 SHALL behave as 2.
REQ-017 While en[i] high, cnt SHALL advance cnt+1, and wrap to 0 when cnt equals effective divisor minus 1.
REQ-018 On wrap, active divisor SHALL load pending divisor, so the new divisor governs the period starting at cnt 0.
REQ-019 clk_out[i] SHALL register (next cnt < ceil(Deff/2)), using the divisor governing next cnt; odd D gives the longer phase high.
REQ-020 tick[i] SHALL be 1 for exactly the cycle in which clk_out[i] goes from 0 to 1, else 0.
REQ-021 While en[i] low, cnt SHALL be held at 0, clk_out[i] SHALL be 0, and tick[i] SHALL be 0.
REQ-022 On the first cycle en[i] is sampled high after low, the next cnt is 0, so clk_out[i] and tick[i] SHALL become 1 one cycle later; pending divisor SHALL load at that restart.
REQ-023 div_wr with div_ch < NUM_CH SHALL write div_val to that channel's pending divisor only; div_ch >= NUM_CH SHALL be ignored entirely.
REQ-024 Write in the same cycle as a wrap SHALL land in pending and apply at the following wrap, never mid-period.
REQ-025 Multiple writes before a wrap: last write SHALL win.
REQ-026 A state machine SHALL have states RESET_WAIT, LOCKED and RELOCK.
REQ-027 RESET_WAIT SHALL count LOCK_CYCLES cycles and then go to LOCKED.
REQ-028 In LOCKED, any accepted div_wr SHALL go to RELOCK.
REQ-029 RELOCK SHALL wait until every channel whose pending differs from active has wrapped or is disabled, then count LOCK_CYCLES and go to LOCKED.
REQ-030 An accepted write during RELOCK SHALL restart the RELOCK wait.
REQ-031 locked SHALL be 1 only in state LOCKED.
REQ-032 rst_out_n SHALL release through a 2-flop chain once RESET_WAIT first exits, and SHALL stay high through RELOCK.

Reset
REQ-033 rst_n low SHALL immediately force: cnt 0, active and pending divisor DEFAULT_DIV, clk_out 0, tick 0, state RESET_WAIT, locked 0, rst_out_n 0.
REQ-034 Reset asserted mid-period SHALL abandon the period with no further tick; after release, channels with en high SHALL restart per REQ-022.

Verification
REQ-035 Bench SHALL cover: reset release, en=2'b11, defaults -> clk_out toggles every cycle (period 2), tick every 2 cycles, locked at cycle 16 after release, rst_out_n 2 cycles later.
REQ-036 Bench SHALL cover: write ch0 D=5 mid-period -> current period completes at old D, then ch0 high 3 / low 2 per period, tick every 5 cycles; locked drops, reasserts 16 cycles after the wrap.
REQ-037 Bench SHALL cover: write ch1 D=0, then D=1 -> both behave as period 2; write ch=5 with NUM_CH=2 -> no divisor change and locked stays 1.
REQ-038 Bench SHALL cover: deassert en[0] for 7 cycles and then reassert -> clk_out[0]=0 while disabled; clk_out and tick become 1 one cycle after en sampled high.
REQ-039 Bench SHALL cover: write on exact wrap cycle and two back-to-back writes (D=4, then D=6) -> only 6 applies, at the next wrap.
REQ-040 Bench SHALL cover: rst_n pulse mid-period -> all outputs reach reset values asynchronously and the full lock sequence repeats.
